ras: RTL and testbench

RAS -- requirements
Module: ras

---
 rtl/ras.sv | 81 ++++++++
 tb/tb_ras.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ras.sv
// rtl/ras.sv - Return address stack: circular array with a checkpointable top pointer.
// Optional RAS_PERF_EN adds saturating push/restore counters.
module ras #(
  parameter int RAS_ENTRIES      = 8,
  parameter int RAS_INDEX_WIDTH  = 3,
  parameter int RAS_TARGET_WIDTH = 31
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic                        link_valid_in,
  input  logic [RAS_TARGET_WIDTH-1:0] link_target_in,
  input  logic                        ret_valid_in,
  output logic [RAS_TARGET_WIDTH-1:0] ret_target_out,
  output logic [RAS_INDEX_WIDTH-1:0]  ras_index_out,
  input  logic                        update_valid_in,
  input  logic [RAS_INDEX_WIDTH-1:0]  update_ras_index_in
`ifdef RAS_PERF_EN
  ,
  output logic [15:0]                 perf_push_count_out,
  output logic [15:0]                 perf_restore_count_out
`endif
);

  logic [RAS_TARGET_WIDTH-1:0] entries [RAS_ENTRIES];
  logic [RAS_INDEX_WIDTH-1:0]  top;
  logic [RAS_INDEX_WIDTH-1:0]  top_next;
  logic [RAS_INDEX_WIDTH-1:0]  wr_idx;
  logic                        wr_en;

  assign ret_target_out = entries[top];
  assign ras_index_out  = top;

  // Restore wins outright; pop-then-push rewrites the current top in place.
  always_comb begin
    top_next = top;
    wr_idx   = top;
    wr_en    = 1'b0;
    if (update_valid_in) begin
      top_next = update_ras_index_in;
    end else if (link_valid_in && ret_valid_in) begin
      wr_en = 1'b1;
    end else if (link_valid_in) begin
      top_next = top + RAS_INDEX_WIDTH'(1);
      wr_idx   = top + RAS_INDEX_WIDTH'(1);
      wr_en    = 1'b1;
    end else if (ret_valid_in) begin
      top_next = top - RAS_INDEX_WIDTH'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      top <= '0;
      for (int i = 0; i < RAS_ENTRIES; i++) begin
        entries[i] <= '0;
      end
    end else begin
      top <= top_next;
      if (wr_en) begin
        entries[wr_idx] <= link_target_in;
      end
    end
  end

`ifdef RAS_PERF_EN
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      perf_push_count_out    <= '0;
      perf_restore_count_out <= '0;
    end else begin
      if (wr_en && perf_push_count_out != 16'hFFFF) begin
        perf_push_count_out <= perf_push_count_out + 16'd1;
      end
      if (update_valid_in && perf_restore_count_out != 16'hFFFF) begin
        perf_restore_count_out <= perf_restore_count_out + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ras.sv
// tb/tb_ras.sv - Scoreboard bench for ras against a behavioural stack model.
module tb_ras;
  localparam int N  = 8;
  localparam int IW = 3;
  localparam int TW = 31;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          link_valid_in = 1'b0;
  logic [TW-1:0] link_target_in = '0;
  logic          ret_valid_in = 1'b0;
  logic [TW-1:0] ret_target_out;
  logic [IW-1:0] ras_index_out;
  logic          update_valid_in = 1'b0;
  logic [IW-1:0] update_ras_index_in = '0;
`ifdef RAS_PERF_EN
  logic [15:0]   perf_push_count_out;
  logic [15:0]   perf_restore_count_out;
`endif

  ras #(.RAS_ENTRIES(N), .RAS_INDEX_WIDTH(IW), .RAS_TARGET_WIDTH(TW)) dut (
    .CLK(CLK),
    .nRST(nRST),
    .link_valid_in(link_valid_in),
    .link_target_in(link_target_in),
    .ret_valid_in(ret_valid_in),
    .ret_target_out(ret_target_out),
    .ras_index_out(ras_index_out),
    .update_valid_in(update_valid_in),
    .update_ras_index_in(update_ras_index_in)
`ifdef RAS_PERF_EN
    ,
    .perf_push_count_out(perf_push_count_out),
    .perf_restore_count_out(perf_restore_count_out)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int idx;
    int tgt;
    int pc;
    int rc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: a ring of return addresses and a top index.
  int   m_mem [N];
  int   m_top;
  int   m_pc;
  int   m_rc;
  bit   m_valid = 0;

  task automatic step(input bit rst, input bit push, input int tgt,
                      input bit pop, input bit upd, input int ui);
    exp_t e;
    @(posedge CLK);
    #1;
    nRST                = rst;
    link_valid_in       = push;
    link_target_in      = TW'(tgt);
    ret_valid_in        = pop;
    update_valid_in     = upd;
    update_ras_index_in = IW'(ui);
    if (m_valid) begin
      e.idx = m_top;
      e.tgt = m_mem[m_top];
      e.pc  = m_pc;
      e.rc  = m_rc;
      exp_q.push_back(e);
    end
    if (!rst) begin
      foreach (m_mem[i]) m_mem[i] = 0;
      m_top   = 0;
      m_pc    = 0;
      m_rc    = 0;
      m_valid = 1;
    end else if (upd) begin
      m_top = ui % N;
      if (m_rc < 65535) m_rc++;
    end else if (push) begin
      if (!pop) m_top = (m_top + 1) % N;
      m_mem[m_top] = tgt & 32'h7FFF_FFFF;
      if (m_pc < 65535) m_pc++;
    end else if (pop) begin
      m_top = (m_top + N - 1) % N;
    end
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (int'(ras_index_out) != e.idx) begin
        errors++;
        $display("FAIL ras_index_out got %0d want %0d at %0t", ras_index_out, e.idx, $time);
      end
      checks++;
      if (int'(ret_target_out) != e.tgt) begin
        errors++;
        $display("FAIL ret_target_out got %0h want %0h at %0t", ret_target_out, e.tgt, $time);
      end
`ifdef RAS_PERF_EN
      checks++;
      if (int'(perf_push_count_out) != e.pc) begin
        errors++;
        $display("FAIL perf_push_count got %0d want %0d", perf_push_count_out, e.pc);
      end
      checks++;
      if (int'(perf_restore_count_out) != e.rc) begin
        errors++;
        $display("FAIL perf_restore_count got %0d want %0d", perf_restore_count_out, e.rc);
      end
`endif
    end
  end

  initial begin
    do_reset();
    do_reset();
    idle();

    // Three pushes then three pops.
    step(1, 1, 'h100, 0, 0, 0);
    step(1, 1, 'h200, 0, 0, 0);
    step(1, 1, 'h300, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0, 0);
    idle();

    // Overflow wrap: nine pushes, eight pops.
    do_reset();
    for (int i = 1; i <= 9; i++) step(1, 1, i, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 1, 0, 0);
    idle();

    // Simultaneous push and pop at top=2.
    do_reset();
    step(1, 1, 'h11, 0, 0, 0);
    step(1, 1, 'h55, 0, 0, 0);
    step(1, 1, 'h77, 1, 0, 0);
    idle();

    // Restore beats a same-cycle push; revisit entries 3 and 6.
    do_reset();
    for (int i = 1; i <= 5; i++) step(1, 1, 'h40 + i, 0, 0, 0);
    step(1, 1, 'hDEAD, 0, 1, 2);
    step(1, 0, 0, 0, 1, 6);
    step(1, 0, 0, 1, 1, 3);
    idle();

    // Pop from reset underflows to the last slot.
    do_reset();
    step(1, 0, 0, 1, 0, 0);
    idle();

`ifdef RAS_PERF_EN
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 1, 'h500 + i, 0, 0, 0);
    step(1, 1, 'h600, 0, 1, 1);
    step(1, 0, 0, 0, 1, 2);
    step(1, 0, 0, 0, 1, 0);
    idle();
    for (int i = 0; i < 65540; i++) step(1, 1, i, i[0], 0, 0);
    idle();
`endif

    // Randomised traffic with occasional mid-stream reset.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bit rst;
      rst = ($urandom_range(0, 49) != 0);
      step(rst, $urandom_range(0, 1) == 1, int'($urandom()),
           $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
           int'($urandom_range(0, N - 1)));
    end
    idle();
    idle();

    @(posedge CLK);
    @(negedge CLK);
    @(negedge CLK);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
